// File: rtl/led_blink_multi.sv
// led_blink_multi: CH independent LED channels, each OFF/ON/BLINK/PULSE with programmable on/off durations.
// Outputs trail the channel phase by one register; done pulses on the edge where a PULSE output falls.
module led_blink_multi #(
    parameter int CH       = 4,
    parameter int TW       = 8,
    parameter int DEF_ON   = 50,
    parameter int DEF_OFF  = 50,
    parameter int RST_MODE = 2
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          cfg_valid_i,
    input  logic [3:0]    cfg_ch_i,
    input  logic [1:0]    cfg_mode_i,
    input  logic [TW-1:0] cfg_on_i,
    input  logic [TW-1:0] cfg_off_i,
    input  logic          sync_i,
    output logic [CH-1:0] out_o,
    output logic [CH-1:0] done_o,
    output logic          cfg_err_o
);
    localparam logic [1:0] M_OFF   = 2'd0;
    localparam logic [1:0] M_ON    = 2'd1;
    localparam logic [1:0] M_BLINK = 2'd2;
    localparam logic [1:0] M_PULSE = 2'd3;

    logic err_q, err_d;

    assign err_d     = cfg_valid_i && int'(cfg_ch_i) >= CH;
    assign cfg_err_o = err_q;

    always_ff @(posedge clk_i or negedge rst_ni)
        if (!rst_ni) err_q <= 1'b0;
        else         err_q <= err_d;

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [1:0]    mode_q, mode_d;
        logic [TW-1:0] on_q, on_d, off_q, off_d, cnt_q, cnt_d, len, last;
        logic          ph_q, ph_d, fin_q, fin_d, out_q, done_q, wr;

        assign wr   = cfg_valid_i && cfg_ch_i == 4'(c);
        assign len  = ph_q ? on_q : off_q;
        // a zero-length field behaves as one cycle
        assign last = (len == '0) ? '0 : len - 1'b1;

        always_comb begin
            mode_d = mode_q;
            on_d   = on_q;
            off_d  = off_q;
            cnt_d  = cnt_q;
            ph_d   = ph_q;
            fin_d  = 1'b0;
            if (wr) begin
                mode_d = cfg_mode_i;
                on_d   = cfg_on_i;
                off_d  = cfg_off_i;
                cnt_d  = '0;
                ph_d   = cfg_mode_i == M_ON;
            end else if (sync_i && mode_q == M_BLINK) begin
                cnt_d = '0;
                ph_d  = 1'b0;
            end else if (mode_q == M_BLINK || mode_q == M_PULSE) begin
                cnt_d = (cnt_q == last) ? '0 : cnt_q + 1'b1;
                ph_d  = (cnt_q == last) ? ~ph_q : ph_q;
                if (mode_q == M_PULSE && ph_q && cnt_q == last) begin
                    mode_d = M_OFF;
                    fin_d  = 1'b1;
                end
            end else begin
                cnt_d = '0;
                ph_d  = mode_q == M_ON;
            end
        end

        // fin_q delays the terminal event one cycle so done lines up with the falling output
        always_ff @(posedge clk_i or negedge rst_ni)
            if (!rst_ni) begin
                mode_q <= 2'(RST_MODE);
                on_q   <= TW'(DEF_ON);
                off_q  <= TW'(DEF_OFF);
                cnt_q  <= '0;
                ph_q   <= RST_MODE == 1;
                fin_q  <= 1'b0;
                out_q  <= 1'b0;
                done_q <= 1'b0;
            end else begin
                mode_q <= mode_d;
                on_q   <= on_d;
                off_q  <= off_d;
                cnt_q  <= cnt_d;
                ph_q   <= ph_d;
                fin_q  <= fin_d;
                out_q  <= ph_q;
                done_q <= fin_q;
            end

        assign out_o[c]  = out_q;
        assign done_o[c] = done_q;
    end
endmodule

// File: doc/led_blink_multi.md
Name: led_blink_multi

Overview:
- Parametrised, multi-channel successor to the single-LED blinker. Drives CH independent LED outputs.
- Each channel has a run-time programmable mode (off / on / blink / one-shot pulse) and programmable on and off durations.
- Sits between the board-control logic and the LED pins. Each output has one registered sync stage, matching the existing OUT_SYNC=1 convention.

Parameters:
- CH, 4, number of channels (1..16).
- TW, 8, width of the on/off duration fields and channel counters.
- DEF_ON, 50, on-duration (cycles) loaded at reset into every channel.
- DEF_OFF, 50, off-duration (cycles) loaded at reset into every channel.
- RST_MODE, 2, mode loaded at reset into every channel (0=OFF, 1=ON, 2=BLINK, 3=PULSE).

Ports:
- clk  in  1  system clock; all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- cfg_valid  in  1  one-cycle config write strobe.
- cfg_ch  in  4  target channel index.
- cfg_mode  in  2  mode for the target channel.
- cfg_on  in  TW  on-duration in cycles.
- cfg_off  in  TW  off-duration in cycles.
- sync  in  1  restart all BLINK channels in phase.
- out  out  CH  registered LED outputs.
- done  out  CH  one-cycle pulse at the end of a PULSE.
- cfg_err  out  1  one-cycle pulse on a write to cfg_ch >= CH.

Behaviour:
- Reset (reset=0, asynchronous):
  - Every channel: mode=RST_MODE, on_len=DEF_ON, off_len=DEF_OFF, cnt=0.
  - phase=ON if RST_MODE=1, otherwise OFF.
  - out=0, done=0, cfg_err=0.
  - Reset asserted mid-operation aborts everything immediately; no done pulse is produced.
- Duration rule: a length field of 0 is treated as 1. Counters never wrap past len-1.
- Per-channel step, every cycle:
  - In BLINK or PULSE: if cnt == len(phase)-1, then cnt<=0 and phase toggles; otherwise cnt<=cnt+1.
  - In OFF or ON: cnt holds at 0; phase is forced OFF or ON respectively.
- Output stage:
  - out[i] <= phase[i], i.e. one cycle of latency.
  - With BLINK and off_len=L after reset release: out stays 0 through edge L and goes 1 at edge L+1 (edge 1 is the first edge with reset=1).
  - It then returns to 0 exactly on_len cycles later.
- PULSE mode:
  - Runs one OFF phase of off_len cycles, then one ON phase of on_len cycles.
  - On the ON→OFF toggle, the channel's mode becomes OFF.
  - done[i] is registered and pulses high for 1 cycle, on the same edge that out[i] falls.
- Config write (cfg_valid=1, cfg_ch<CH):
  - Next edge loads mode, on_len and off_len, and clears cnt.
  - phase = ON for mode 1, OFF otherwise. This restarts the channel from the start of its OFF phase.
  - No other channel is affected.
- Config write with cfg_ch >= CH: no state changes; cfg_err=1 on the next cycle.
- sync=1: every channel in BLINK gets cnt<=0 and phase<=OFF. Channels in other modes ignore it.
- Simultaneous events:
  - cfg_valid and sync in the same cycle: the addressed channel takes the config load; all other BLINK channels take the sync restart.
  - A config write landing on the PULSE terminal cycle wins: done is not asserted and the new config is loaded.
- A config write with identical values still restarts the channel.
- Channels are fully independent; there is no shared counter.

Test Plan:
- Reset defaults (CH=4, DEF_ON=DEF_OFF=50, RST_MODE=2), release reset:
  - out=4'b0000 through edge 50, 4'b1111 from edge 51, 4'b0000 again from edge 101.
- Write ch1 ON, then ch2 OFF:
  - out[1]=1 one cycle after the next edge and stays 1; out[2]=0 permanently; ch0 and ch3 keep blinking unaffected.
- Write ch3 PULSE with off=3, on=5:
  - out[3] rises 4 edges after the write edge, stays high 5 cycles, then falls together with a single-cycle done[3].
  - Mode then reads as OFF: no further pulses over 200 cycles.
- Write ch0 BLINK with on=0, off=0:
  - out[0] toggles every cycle (period 2).
- Restart behaviour:
  - Write cfg_ch=7: cfg_err pulses once; out is undisturbed.
  - Stagger ch0 and ch2 via writes, then assert sync: both channels show identical out waveforms afterwards.
- Reset mid-PULSE:
  - Assert reset during the ON phase: out=0 and done=0 immediately (asynchronously).
  - After release the channel restarts in RST_MODE.
